// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared definitions for the video timing generator.
//   pattern_t    - run-time test pattern selection (matches pattern_sel encoding)
//   VGA_*        - 640x480 @ 60 Hz default geometry
//   SIM_*        - 320x240 reduced geometry for faster simulation
package video_timing_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int SIM_H_ACTIVE = 320;
  localparam int SIM_H_FP     = 8;
  localparam int SIM_H_SYNC   = 48;
  localparam int SIM_H_BP     = 24;
  localparam int SIM_V_ACTIVE = 240;
  localparam int SIM_V_FP     = 5;
  localparam int SIM_V_SYNC   = 2;
  localparam int SIM_V_BP     = 16;

endpackage

// File: rtl/video_timing_gen_pattern.sv
// video_pattern: combinational test-pattern colour generator.
//   i_h_cnt / i_v_cnt - current pixel counters
//   i_pat             - pattern latched for this frame
//   i_frame_cnt       - frame counter (animates the gradient blue channel)
//   i_bar_idx         - colour-bar index 0..7 from the bar down-counter
//   o_red/green/blue  - unregistered colour, not yet blank-qualified
module video_pattern
  import video_timing_pkg::*;
#(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int CB = 3
) (
  input  logic [HW-1:0] i_h_cnt,
  input  logic [VW-1:0] i_v_cnt,
  input  pattern_t      i_pat,
  input  logic [7:0]    i_frame_cnt,
  input  logic [2:0]    i_bar_idx,
  output logic [CB-1:0] o_red,
  output logic [CB-1:0] o_green,
  output logic [CB-1:0] o_blue
);

  logic [CB-1:0] w_h_grad;
  logic [CB-1:0] w_v_grad;
  logic [CB-1:0] w_f_grad;
  logic          w_check;

  // Shift-then-resize: bits beyond the counter width read as zero.
  assign w_h_grad = CB'(i_h_cnt >> 4);
  assign w_v_grad = CB'(i_v_cnt >> 4);
  assign w_f_grad = CB'(i_frame_cnt);
  assign w_check  = 1'(i_h_cnt >> 4) ^ 1'(i_v_cnt >> 4);

  always_comb begin
    o_red   = '0;
    o_green = '0;
    o_blue  = '0;
    case (i_pat)
      PAT_SOLID: begin
        o_red   = '1;
        o_green = '1;
        o_blue  = '1;
      end
      PAT_BARS: begin
        o_red   = {CB{i_bar_idx[2]}};
        o_green = {CB{i_bar_idx[1]}};
        o_blue  = {CB{i_bar_idx[0]}};
      end
      PAT_CHECK: begin
        o_red   = {CB{w_check}};
        o_green = {CB{w_check}};
        o_blue  = {CB{w_check}};
      end
      PAT_GRAD: begin
        o_red   = w_h_grad;
        o_green = w_v_grad;
        o_blue  = w_f_grad;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised video timing and test-pattern generator.
//   clk, rst_n      - pixel clock, async active-low reset
//   en              - advance one pixel per clock when 1, hold everything when 0
//   pattern_sel     - test pattern, sampled once per frame at pixel (0,0)
//   hsync, vsync    - syncs, active level set by H_POL / V_POL
//   blank           - 1 outside the active region (RGB forced to 0)
//   red/green/blue  - pixel colour, COLOR_BITS per channel
//   x, y            - counter values of the pixel currently on the outputs
//   frame_start     - high with pixel (0,0); line_start - high with x=0
// All outputs are registered: outputs after an edge describe the counter
// state that existed before that edge.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int COLOR_BITS = 3,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            pattern_sel,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic [HW-1:0]         x,
  output logic [VW-1:0]         y,
  output logic                  frame_start,
  output logic                  line_start
);

  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  // One extra bit so a sync end equal to the total does not overflow.
  localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SS_E   = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SE_E   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SS_E   = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SE_E   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [7:0]    r_frame_cnt;
  pattern_t      r_pat_q;
  logic [HW-1:0] r_bar_cnt;
  logic [2:0]    r_bar_idx;

  logic            w_h_wrap;
  logic            w_v_wrap;
  logic            w_line0;
  logic            w_origin;
  logic            w_active;
  logic            w_hs_on;
  logic            w_vs_on;
  pattern_t        w_pat;
  logic [COLOR_BITS-1:0] w_red;
  logic [COLOR_BITS-1:0] w_green;
  logic [COLOR_BITS-1:0] w_blue;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_line0  = (r_h_cnt == '0);
  assign w_origin = w_line0 && (r_v_cnt == '0);
  assign w_active = ({1'b0, r_h_cnt} < H_ACT_E) && ({1'b0, r_v_cnt} < V_ACT_E);
  assign w_hs_on  = ({1'b0, r_h_cnt} >= H_SS_E) && ({1'b0, r_h_cnt} < H_SE_E);
  assign w_vs_on  = ({1'b0, r_v_cnt} >= V_SS_E) && ({1'b0, r_v_cnt} < V_SE_E);

  // Pixel (0,0) is rendered with the pattern being latched on that same
  // edge, so a whole frame always shows one pattern.
  assign w_pat = w_origin ? pattern_t'(pattern_sel) : r_pat_q;

  video_pattern #(
    .HW (HW),
    .VW (VW),
    .CB (COLOR_BITS)
  ) u_pattern (
    .i_h_cnt     (r_h_cnt),
    .i_v_cnt     (r_v_cnt),
    .i_pat       (w_pat),
    .i_frame_cnt (r_frame_cnt),
    .i_bar_idx   (r_bar_idx),
    .o_red       (w_red),
    .o_green     (w_green),
    .o_blue      (w_blue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
      r_pat_q     <= PAT_SOLID;
      r_bar_cnt   <= BAR_LAST;
      r_bar_idx   <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      blank       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + VW'(1);
        if (w_v_wrap) r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end

      if (w_origin) r_pat_q <= pattern_t'(pattern_sel);

      // Bar state tracks r_h_cnt: index/count describe the pixel being counted.
      if (w_h_wrap) begin
        r_bar_cnt <= BAR_LAST;
        r_bar_idx <= '0;
      end else if (r_bar_cnt == '0) begin
        r_bar_cnt <= BAR_LAST;
        if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt - HW'(1);
      end

      hsync       <= w_hs_on ? H_POL : ~H_POL;
      vsync       <= w_vs_on ? V_POL : ~V_POL;
      blank       <= ~w_active;
      red         <= w_active ? w_red   : '0;
      green       <= w_active ? w_green : '0;
      blue        <= w_active ? w_blue  : '0;
      x           <= r_h_cnt;
      y           <= r_v_cnt;
      frame_start <= w_origin;
      line_start  <= w_line0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen.
// Two instances share clock/reset/enable:
//   u_dut_a : 64x40 active, total 96x50, active-low syncs, 3-bit colour
//   u_dut_b : 32x16 active, total 48x23, active-high syncs, 2-bit colour
// The driver pushes hand-computed pixel vectors (frame, x, y, outputs) and
// reset snapshots into queues; monitors pop and compare when the DUT
// presents a pixel (en=1 edge) or when reset is asserted.
module tb_video_timing_gen;

  localparam int AHT = 96;
  localparam int AFT = 96 * 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] pattern_sel;

  logic       a_hs, a_vs, a_bl, a_fs, a_ls;
  logic [2:0] a_r, a_g, a_b;
  logic [6:0] a_x;
  logic [5:0] a_y;

  logic       b_hs, b_vs, b_bl, b_fs, b_ls;
  logic [1:0] b_r, b_g, b_b;
  logic [5:0] b_x;
  logic [4:0] b_y;

  video_timing_gen #(
    .H_ACTIVE (64), .H_FP (8), .H_SYNC (16), .H_BP (8),
    .V_ACTIVE (40), .V_FP (3), .V_SYNC (2),  .V_BP (5),
    .H_POL (1'b0), .V_POL (1'b0), .COLOR_BITS (3)
  ) u_dut_a (
    .clk (clk), .rst_n (rst_n), .en (en), .pattern_sel (pattern_sel),
    .hsync (a_hs), .vsync (a_vs), .blank (a_bl),
    .red (a_r), .green (a_g), .blue (a_b),
    .x (a_x), .y (a_y), .frame_start (a_fs), .line_start (a_ls)
  );

  video_timing_gen #(
    .H_ACTIVE (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (16), .V_FP (2), .V_SYNC (3), .V_BP (2),
    .H_POL (1'b1), .V_POL (1'b1), .COLOR_BITS (2)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .en (en), .pattern_sel (pattern_sel),
    .hsync (b_hs), .vsync (b_vs), .blank (b_bl),
    .red (b_r), .green (b_g), .blue (b_b),
    .x (b_x), .y (b_y), .frame_start (b_fs), .line_start (b_ls)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          f;
    int          x;
    int          y;
    logic [13:0] e;
    string       nm;
  } vec_t;

  vec_t        q_px[$];
  logic [63:0] q_rst[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [13:0] pack(logic hs, logic vs, logic bl,
                                       logic [2:0] r, logic [2:0] g, logic [2:0] b,
                                       logic fs, logic ls);
    return {hs, vs, bl, r, g, b, fs, ls};
  endfunction

  function automatic logic [63:0] bundle();
    return 64'({pack(a_hs, a_vs, a_bl, a_r, a_g, a_b, a_fs, a_ls), a_x, a_y,
                pack(b_hs, b_vs, b_bl, 3'(b_r), 3'(b_g), 3'(b_b), b_fs, b_ls),
                b_x, b_y});
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no matching pixel, expected one (t=%0t)", nm, $time);
  endtask

  task automatic pv(input string nm, input int f, input int x, input int y,
                    input logic hs, input logic vs, input logic bl,
                    input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                    input logic fs, input logic ls);
    vec_t v;
    v.f = f; v.x = x; v.y = y;
    v.e = pack(hs, vs, bl, r, g, b, fs, ls);
    v.nm = $sformatf("%s@f%0d(%0d,%0d)", nm, f, x, y);
    q_px.push_back(v);
  endtask

  // Reset snapshot: A idles high (active-low syncs), B idles low.
  localparam logic [63:0] RST_EXP =
    64'({14'b1_1_1_000_000_000_0_0, 7'd0, 6'd0,
         14'b0_0_1_000_000_000_0_0, 6'd0, 5'd0});

  // ---------------- reset monitor ----------------
  always @(negedge rst_n) begin
    #1;
    if (q_rst.size() == 0) miss("reset_unexpected");
    else check("reset_values", bundle(), q_rst.pop_front());
  end

  // ---------------- pixel / timing monitor ----------------
  int          fidx = -1;
  logic [63:0] snap;
  bit          snap_ok = 1'b0;

  int m_line[2], m_frame[2], m_hrun[2], m_hx[2], m_vrun[2], m_vy[2];
  bit m_lok[2], m_fok[2];

  task automatic meas_clear();
    for (int i = 0; i < 2; i++) begin
      m_line[i] = 0; m_frame[i] = 0; m_hrun[i] = 0; m_hx[i] = 0;
      m_vrun[i] = 0; m_vy[i] = 0; m_lok[i] = 1'b0; m_fok[i] = 1'b0;
    end
  endtask

  task automatic measure(input int id, input logic hs, input logic vs, input logic bl,
                         input logic ls, input logic fs, input int x, input int y,
                         input logic pol, input int ht, input int ft,
                         input int hss, input int hsw, input int vss, input int vsw,
                         input int ha, input int va);
    if (ls) begin
      if (m_lok[id]) check($sformatf("line_len%0d", id), 64'(m_line[id]), 64'(ht));
      m_line[id] = 0;
      m_lok[id]  = 1'b1;
      if (vs == pol) begin
        if (m_vrun[id] == 0) m_vy[id] = y;
        m_vrun[id]++;
      end else if (m_vrun[id] > 0) begin
        check($sformatf("vsync_lines_start%0d", id),
              {32'(m_vrun[id]), 32'(m_vy[id])}, {32'(vsw), 32'(vss)});
        m_vrun[id] = 0;
      end
    end
    m_line[id]++;
    if (fs) begin
      if (m_fok[id]) check($sformatf("frame_len%0d", id), 64'(m_frame[id]), 64'(ft));
      m_frame[id] = 0;
      m_fok[id]   = 1'b1;
    end
    m_frame[id]++;
    if (hs == pol) begin
      if (m_hrun[id] == 0) m_hx[id] = x;
      m_hrun[id]++;
    end else if (m_hrun[id] > 0) begin
      check($sformatf("hsync_width_start%0d", id),
            {32'(m_hrun[id]), 32'(m_hx[id])}, {32'(hsw), 32'(hss)});
      m_hrun[id] = 0;
    end
    check($sformatf("blank%0d(%0d,%0d)", id, x, y), 64'(bl), 64'(!(x < ha && y < va)));
  endtask

  initial meas_clear();

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      snap_ok = 1'b0;
      meas_clear();
    end else if (en) begin
      if (a_fs) fidx++;
      while (q_px.size() > 0 &&
             (q_px[0].f < fidx ||
              (q_px[0].f == fidx &&
               q_px[0].y * 4096 + q_px[0].x < int'(a_y) * 4096 + int'(a_x)))) begin
        miss(q_px[0].nm);
        void'(q_px.pop_front());
      end
      if (q_px.size() > 0 && q_px[0].f == fidx &&
          q_px[0].x == int'(a_x) && q_px[0].y == int'(a_y)) begin
        check(q_px[0].nm, 64'(pack(a_hs, a_vs, a_bl, a_r, a_g, a_b, a_fs, a_ls)),
              64'(q_px[0].e));
        void'(q_px.pop_front());
      end
      measure(0, a_hs, a_vs, a_bl, a_ls, a_fs, int'(a_x), int'(a_y), 1'b0,
              96, 4800, 72, 16, 43, 2, 64, 40);
      measure(1, b_hs, b_vs, b_bl, b_ls, b_fs, int'(b_x), int'(b_y), 1'b1,
              48, 1104, 36, 8, 18, 3, 32, 16);
      snap    = bundle();
      snap_ok = 1'b1;
    end else if (snap_ok) begin
      check("freeze", bundle(), snap);
    end
  end

  // ---------------- driver ----------------
  int cur_f = 0;
  int pif   = 0;

  task automatic tick();
    @(negedge clk);
    if (en && rst_n) begin
      pif++;
      if (pif == AFT) begin
        pif = 0;
        cur_f++;
      end
    end
  endtask

  task automatic adv_to(input int f, input int y, input int x);
    while (!(cur_f == f && pif == y * AHT + x)) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    pattern_sel = 2'd0;
    #2;
    q_rst.push_back(RST_EXP);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // frame 0: solid white, sync/blank boundaries
    pv("solid",      0,  0,  0, 1, 1, 0, 7, 7, 7, 1, 1);
    pv("h_blank",    0, 64,  0, 1, 1, 1, 0, 0, 0, 0, 0);
    pv("hs_first",   0, 72,  0, 0, 1, 1, 0, 0, 0, 0, 0);
    pv("hs_last",    0, 87,  0, 0, 1, 1, 0, 0, 0, 0, 0);
    pv("hs_end",     0, 88,  0, 1, 1, 1, 0, 0, 0, 0, 0);
    pv("solid_last", 0, 63, 39, 1, 1, 0, 7, 7, 7, 0, 0);
    pv("v_blank",    0,  0, 40, 1, 1, 1, 0, 0, 0, 0, 1);
    pv("vs_first",   0,  0, 43, 1, 0, 1, 0, 0, 0, 0, 1);
    pv("vs_last",    0, 95, 44, 1, 0, 1, 0, 0, 0, 0, 0);
    pv("vs_end",     0,  0, 45, 1, 1, 1, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    en = 1'b1;

    // mid-frame select change: frame 0 stays solid, frame 1 shows bars
    adv_to(0, 10, 0);
    pattern_sel = 2'd1;
    pv("bar0",      1,  0,  0, 1, 1, 0, 0, 0, 0, 1, 1);
    pv("bar0_end",  1,  7,  0, 1, 1, 0, 0, 0, 0, 0, 0);
    pv("bar1",      1,  8,  0, 1, 1, 0, 0, 0, 7, 0, 0);
    pv("bar2",      1, 16,  0, 1, 1, 0, 0, 7, 0, 0, 0);
    pv("bar3",      1, 24,  0, 1, 1, 0, 0, 7, 7, 0, 0);
    pv("bar4",      1, 32,  0, 1, 1, 0, 7, 0, 0, 0, 0);
    pv("bar5",      1, 40,  0, 1, 1, 0, 7, 0, 7, 0, 0);
    pv("bar6",      1, 48,  0, 1, 1, 0, 7, 7, 0, 0, 0);
    pv("bar7",      1, 56,  0, 1, 1, 0, 7, 7, 7, 0, 0);
    pv("bar7_end",  1, 63,  0, 1, 1, 0, 7, 7, 7, 0, 0);
    pv("bar_blank", 1, 64,  0, 1, 1, 1, 0, 0, 0, 0, 0);
    pv("bar1_l5",   1,  8,  5, 1, 1, 0, 0, 0, 7, 0, 0);
    pv("bar7_l5",   1, 56,  5, 1, 1, 0, 7, 7, 7, 0, 0);

    adv_to(1, 20, 0);
    pattern_sel = 2'd2;
    pv("bars_held", 1,  8, 30, 1, 1, 0, 0, 0, 7, 0, 0);
    pv("chk00",     2,  0,  0, 1, 1, 0, 0, 0, 0, 1, 1);
    pv("chk15",     2, 15,  0, 1, 1, 0, 0, 0, 0, 0, 0);
    pv("chk16",     2, 16,  0, 1, 1, 0, 7, 7, 7, 0, 0);
    pv("chk32",     2, 32,  0, 1, 1, 0, 0, 0, 0, 0, 0);
    pv("chk0_16",   2,  0, 16, 1, 1, 0, 7, 7, 7, 0, 1);
    pv("chk16_16",  2, 16, 16, 1, 1, 0, 0, 0, 0, 0, 0);
    pv("chk48_20",  2, 48, 20, 1, 1, 0, 0, 0, 0, 0, 0);

    adv_to(2, 20, 0);
    pattern_sel = 2'd3;
    pv("grad_f3",    3,  0,  0, 1, 1, 0, 0, 0, 3, 1, 1);
    pv("grad_r1",    3, 16,  0, 1, 1, 0, 1, 0, 3, 0, 0);
    pv("grad_mid",   3, 48, 33, 1, 1, 0, 3, 2, 3, 0, 0);
    pv("grad_f4",    4,  0,  0, 1, 1, 0, 0, 0, 4, 1, 1);
    pv("grad_f5",    5,  0,  0, 1, 1, 0, 0, 0, 5, 1, 1);
    pv("resume",     5, 20, 10, 1, 1, 0, 1, 0, 5, 0, 0);
    pv("grad_f5end", 5, 63, 39, 1, 1, 0, 3, 2, 5, 0, 0);

    // hold for 37 cycles mid-line
    adv_to(5, 10, 20);
    en = 1'b0;
    repeat (37) tick();
    en = 1'b1;

    // asynchronous reset between edges, mid-frame
    adv_to(6, 12, 30);
    #3;
    q_rst.push_back(RST_EXP);
    rst_n = 1'b0;
    repeat (3) tick();
    pv("post_rst",  7,  0,  0, 1, 1, 0, 0, 0, 0, 1, 1);
    pv("post_r1",   7, 16,  0, 1, 1, 0, 1, 0, 0, 0, 0);
    pv("blue_f1",   8,  0,  0, 1, 1, 0, 0, 0, 1, 1, 1);
    pv("blue_f2",   9,  0,  0, 1, 1, 0, 0, 0, 2, 1, 1);
    rst_n = 1'b1;
    cur_f = 7;
    pif = 0;

    adv_to(9, 1, 0);
    repeat (2) tick();
    while (q_px.size() > 0) begin
      miss(q_px[0].nm);
      void'(q_px.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing and test-pattern generator, successor to the fixed-mode `vga` block. It runs in the pixel-clock domain (`vga_clk` from `clk_divn`) and drives `hsync`/`vsync`/`blank`/RGB into `dvid`. Over the fixed block it adds:
- programmable mode geometry and sync polarity;
- a run/hold enable;
- four run-time selectable test patterns, latched per frame;
- pixel coordinate and frame/line-start outputs for downstream overlay logic.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line. Must be a multiple of 8.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: hsync active level (1 = active-high).
- `V_POL`, 0: vsync active level (1 = active-high).
- `COLOR_BITS`, 3: bits per colour channel (≥1).
- Derived localparams:
  - `H_TOTAL` = sum of the four H terms; `V_TOTAL` likewise.
  - `HW` = $clog2(H_TOTAL); `VW` = $clog2(V_TOTAL).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: 1 = advance one pixel per clock; 0 = hold all state.
- `pattern_sel` in 2: test pattern. 0 solid white, 1 colour bars, 2 checkerboard, 3 gradient.
- `hsync` out 1: horizontal sync, polarity per `H_POL`.
- `vsync` out 1: vertical sync, polarity per `V_POL`.
- `blank` out 1: 1 outside the active region.
- `red`, `green`, `blue` out `COLOR_BITS` each: pixel colour.
- `x` out `HW`: horizontal counter value of the current output pixel (0..H_TOTAL-1).
- `y` out `VW`: vertical counter value of the current output pixel (0..V_TOTAL-1).
- `frame_start` out 1: one-cycle pulse with pixel (0,0).
- `line_start` out 1: one-cycle pulse with x=0 on every line, blanking lines included.

## Operation

- Counters `h_cnt` and `v_cnt`:
  - `h_cnt` counts 0..H_TOTAL-1 and wraps to 0.
  - `v_cnt` increments on each `h_cnt` wrap and wraps to 0 after V_TOTAL-1.
  - Both advance only when `en`=1.
- Active region: `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE. `blank` = NOT active.
- `hsync` is at its active level for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- `vsync` is at its active level for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- Pattern latch:
  - `pattern_sel` is sampled into `pat_q` on the cycle where `h_cnt`=0, `v_cnt`=0 and `en`=1.
  - Mid-frame changes have no effect until the next frame.
  - Reset value of `pat_q` is 0.
- Frame counter `frame_cnt` (8 bits):
  - Increments at each wrap of `v_cnt`; wraps 255→0.
  - Resets to 0.
- Patterns. Colour values apply only when not blanked; when `blank`=1, RGB=0 regardless of pattern.
  - 0, solid: all channels all-ones.
  - 1, colour bars: 8 bars, each H_ACTIVE/8 wide. Bar index b (0..7) comes from a bar-width down-counter, not a divider. Each channel is its bit replicated to `COLOR_BITS`: red=b[2], green=b[1], blue=b[0]. Bar 0 is black; bar 7 is white.
  - 2, checkerboard: white if `h_cnt[4]` XOR `v_cnt[4]`, else black (16×16 squares).
  - 3, gradient:
    - red = `h_cnt[4 +: COLOR_BITS]`;
    - green = `v_cnt[4 +: COLOR_BITS]`;
    - blue = `frame_cnt[COLOR_BITS-1:0]`, which animates per frame.
    - Bits beyond the counter width read as 0.

## Timing

- Output latency is one register stage. All outputs are registered; outputs at edge t reflect counter state before edge t.
- `x`/`y` are aligned with the `hsync`/`vsync`/`blank`/RGB of the same pixel.
- While `rst_n`=0 (asynchronous, immediate):
  - counters = 0; `hsync`=!H_POL; `vsync`=!V_POL;
  - `blank`=1; RGB=0; `x`=`y`=0;
  - `frame_start`=`line_start`=0.
- Reset mid-frame aborts the frame. After release with `en`=1:
  - the first edge outputs pixel (0,0) with `frame_start`=1 and `line_start`=1;
  - `pattern_sel` is sampled on that same edge.
- When `en`=0, all outputs and all state hold their values. Pulses therefore stretch while held; downstream logic qualifies them with `en`.
- Simultaneous `h_cnt` and `v_cnt` wrap: both go to 0 on the same edge. `frame_cnt` increments on that edge.
- The bar counter reloads at `h_cnt`=0 and at each bar boundary. b saturates at 7 until `h_cnt` wraps.

## Structure

- Package `video_timing_pkg` holds:
  - pattern-select constants (`PAT_SOLID`, `PAT_BARS`, `PAT_CHECK`, `PAT_GRAD`);
  - 640×480 default timing constants;
  - a 320×240 reduced mode for simulation.
- Sub-module `video_pattern` takes the counters, `pat_q`, `frame_cnt` and bar index, and produces unregistered RGB.
- `video_timing_gen` owns the counters, the sync decode and the output register stage.

## Test plan

1. Reset, `en`=1, default params, `pattern_sel`=0: across 2 frames, check every line is 800 clocks and every frame is 525 lines. `hsync` is low for exactly 96 clocks starting at `x`=656. `vsync` is low for lines 490–491. `blank`=0 exactly for `x`<640 and `y`<480.
2. `pattern_sel`=1: in line 0, RGB changes at `x`=80,160,…,560. At `x`=0 RGB=000; at `x`=639 RGB=777. At `x`=640 RGB=0 (blanked).
3. Change `pattern_sel` 1→2 at line 100: the remainder of the frame stays bars. The next `frame_start` switches to checkerboard: pixel (16,0) white, (16,16) black.
4. `pattern_sel`=3, run 3 frames: blue at pixel (0,0) reads 0,1,2. Red at `x`=16 is 1.
5. Toggle `en`=0 for 37 cycles mid-line: all outputs frozen. On resume, the line completes with the total active clocks still 800.
6. Assert `rst_n`=0 asynchronously mid-frame between clock edges: outputs take reset values immediately. After release, `frame_start` fires on the first edge. Repeat with `H_POL`=`V_POL`=1 and the 320×240 mode: sync idle-low, with pulse widths per parameters.
